// File: rtl/dota_conv_ctrl.sv
// Conversion sequencer for a shared digital OTA/comparator serving two
// channels. A granted channel gets SETTLE_CYC settle cycles, then NSAMP
// comparator samples. The result is a majority vote plus the raw ones count.
//
// Result handshake: res_valid is high for the whole DONE state, and the result
// fields are stable for that time. The result is consumed on the first rising
// edge where res_valid and res_ack are both high. res_ack is ignored while
// res_valid is low.
module dota_conv_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int NSAMP      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       ota_en,
  output logic       ota_sel,
  input  logic       cmp_in,
  output logic       res_valid,
  input  logic       res_ack,
  output logic       res_ch,
  output logic       res_bit,
  output logic [3:0] res_ones,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counters count down to zero. They are reloaded on every state entry,
  // so they never wrap.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] SAMPLE_LD = 4'(NSAMP - 1);
  localparam logic [3:0] HALF      = 4'(NSAMP / 2);

  state_t     state, state_nxt;
  logic       ch, ch_nxt;
  logic       last_ch, last_ch_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] ones, ones_nxt, ones_inc;
  logic       res_ch_nxt, res_bit_nxt;
  logic [3:0] res_ones_nxt;
  logic       conv_nxt;

  assign dbg_state = state;

  // Next-state, arbitration, counters and result capture.
  always_comb begin
    state_nxt    = state;
    ch_nxt       = ch;
    last_ch_nxt  = last_ch;
    cnt_nxt      = cnt;
    ones_nxt     = ones;
    res_ch_nxt   = res_ch;
    res_bit_nxt  = res_bit;
    res_ones_nxt = res_ones;
    ones_inc     = ones + {3'b000, cmp_in};
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LD;
          ones_nxt  = 4'd0;
          case (req)
            2'b01:   ch_nxt = 1'b0;
            2'b10:   ch_nxt = 1'b1;
            default: ch_nxt = ~last_ch;  // tie: round-robin away from last served
          endcase
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_nxt = SAMPLE;
          cnt_nxt   = SAMPLE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      SAMPLE: begin
        ones_nxt = ones_inc;
        if (cnt == 4'd0) begin
          state_nxt    = DONE;
          res_ch_nxt   = ch;
          res_ones_nxt = ones_inc;
          res_bit_nxt  = (ones_inc > HALF);
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        if (res_ack) begin
          state_nxt   = IDLE;
          last_ch_nxt = ch;
        end
      end
      default: state_nxt = IDLE;
    endcase
    conv_nxt = (state_nxt == SETTLE) || (state_nxt == SAMPLE);
  end

  // State, datapath and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= 1'b0;
      last_ch   <= 1'b1;
      cnt       <= 4'd0;
      ones      <= 4'd0;
      res_ch    <= 1'b0;
      res_bit   <= 1'b0;
      res_ones  <= 4'd0;
      gnt       <= 2'b00;
      ota_en    <= 1'b0;
      ota_sel   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      last_ch   <= last_ch_nxt;
      cnt       <= cnt_nxt;
      ones      <= ones_nxt;
      res_ch    <= res_ch_nxt;
      res_bit   <= res_bit_nxt;
      res_ones  <= res_ones_nxt;
      gnt       <= conv_nxt ? (ch_nxt ? 2'b10 : 2'b01) : 2'b00;
      ota_en    <= conv_nxt;
      ota_sel   <= conv_nxt & ch_nxt;
      res_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_dota_conv_ctrl.sv
// Bench for dota_conv_ctrl. Conversions are modelled as whole transactions.
// For each conversion the bench predicts the winning channel, the grant
// window, the result timing and the ones count/vote from the sample pattern.
module tb_dota_conv_ctrl;

  localparam int SETTLE_CYC = 4;
  localparam int NSAMP      = 5;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       ota_en;
  logic       ota_sel;
  logic       cmp_in;
  logic       res_valid;
  logic       res_ack;
  logic       res_ch;
  logic       res_bit;
  logic [3:0] res_ones;
  logic       busy;
  logic [1:0] dbg_state;

  int   n_vec;
  int   n_err;
  logic model_last;

  dota_conv_ctrl #(.SETTLE_CYC(SETTLE_CYC), .NSAMP(NSAMP)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .ota_en(ota_en),
    .ota_sel(ota_sel), .cmp_in(cmp_in), .res_valid(res_valid),
    .res_ack(res_ack), .res_ch(res_ch), .res_bit(res_bit),
    .res_ones(res_ones), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},       32'(gnt),       32'd0);
    chk({tag, "_ota_en"},    32'(ota_en),    32'd0);
    chk({tag, "_ota_sel"},   32'(ota_sel),   32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_ch"},    32'(res_ch),    32'd0);
    chk({tag, "_res_bit"},   32'(res_bit),   32'd0);
    chk({tag, "_res_ones"},  32'(res_ones),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      req = 2'b00;
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_gnt",  32'(gnt),  32'd0);
    end
  endtask

  // One full conversion, starting from an IDLE cycle.
  // mode: 0 = req dropped after one cycle, 1 = req held, 2 = random req.
  task automatic do_conv(input logic [1:0] r, input logic [NSAMP-1:0] bits,
                         input int stall, input int mode);
    logic       exp_ch;
    logic [1:0] exp_gnt;
    int         ones;
    logic       exp_bit;
    exp_ch  = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~model_last;
    exp_gnt = exp_ch ? 2'b10 : 2'b01;
    ones    = $countones(bits);
    exp_bit = (ones > NSAMP / 2);

    req = r;
    step();
    for (int c = 0; c < SETTLE_CYC + NSAMP; c++) begin
      chk("conv_gnt",       32'(gnt),       32'(exp_gnt));
      chk("conv_ota_en",    32'(ota_en),    32'd1);
      chk("conv_ota_sel",   32'(ota_sel),   32'(exp_ch));
      chk("conv_busy",      32'(busy),      32'd1);
      chk("conv_res_valid", 32'(res_valid), 32'd0);
      case (mode)
        0:       req = 2'b00;
        1:       req = r;
        default: req = 2'($urandom);
      endcase
      res_ack = 1'($urandom);
      cmp_in  = (c >= SETTLE_CYC) ? bits[c - SETTLE_CYC] : 1'($urandom);
      step();
    end

    res_ack = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      chk("done_res_valid", 32'(res_valid), 32'd1);
      chk("done_res_ch",    32'(res_ch),    32'(exp_ch));
      chk("done_res_ones",  32'(res_ones),  32'(ones));
      chk("done_res_bit",   32'(res_bit),   32'(exp_bit));
      chk("done_gnt",       32'(gnt),       32'd0);
      chk("done_ota_en",    32'(ota_en),    32'd0);
      chk("done_busy",      32'(busy),      32'd1);
      req     = 2'($urandom);
      cmp_in  = 1'($urandom);
      res_ack = (s == stall);
      step();
    end
    res_ack = 1'b0;
    req     = 2'b00;
    chk("ack_res_valid", 32'(res_valid), 32'd0);
    chk("ack_busy",      32'(busy),      32'd0);
    chk("ack_gnt",       32'(gnt),       32'd0);
    chk("ack_res_ch",    32'(res_ch),    32'(exp_ch));
    chk("ack_res_ones",  32'(res_ones),  32'(ones));
    chk("ack_res_bit",   32'(res_bit),   32'(exp_bit));
    model_last = exp_ch;
  endtask

  // Directed sequence followed by randomized conversions.
  initial begin
    n_vec      = 0;
    n_err      = 0;
    model_last = 1'b1;
    rst        = 1'b1;
    req        = 2'b00;
    cmp_in     = 1'b0;
    res_ack    = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    idle_gap(2);

    // Tie arbitration after reset: ch0, ch1, ch0.
    do_conv(2'b11, NSAMP'($urandom), 0, 1);
    chk("tie1_ch", 32'(res_ch), 32'd0);
    do_conv(2'b11, NSAMP'($urandom), 0, 1);
    chk("tie2_ch", 32'(res_ch), 32'd1);
    do_conv(2'b11, NSAMP'($urandom), 0, 1);
    chk("tie3_ch", 32'(res_ch), 32'd0);

    // Single request, samples 1,1,0,1,0 -> 3 ones, vote 1.
    do_conv(2'b01, 5'b01011, 0, 1);
    // Minority vote on ch1, samples 1,0,0,1,0 -> 2 ones, vote 0.
    do_conv(2'b10, 5'b01001, 1, 1);
    // Long stall in DONE with random requests pending.
    do_conv(2'b01, 5'b11111, 20, 2);
    // Request held for one cycle only.
    idle_gap(1);
    do_conv(2'b01, 5'b10100, 0, 0);

    // Reset during the third sample cycle.
    req    = 2'b01;
    cmp_in = 1'b1;
    step();
    req = 2'b00;
    repeat (SETTLE_CYC + 2) step();
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_gnt",  32'(gnt),  32'd1);
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst        = 1'b0;
    model_last = 1'b1;
    cmp_in     = 1'b0;
    do_conv(2'b11, 5'b00100, 0, 2);

    // Randomized conversions.
    for (int k = 0; k < 25; k++) begin
      idle_gap($urandom_range(0, 2));
      do_conv(2'($urandom_range(1, 3)), NSAMP'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dota_conv_ctrl.md
DOTA_CONV_CTRL -- requirements
Module: dota_conv_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4, meaning comparator settle cycles after enable (legal 1..15).
REQ-002 SHALL have parameter NSAMP, default 5, meaning comparator samples per conversion (odd, legal 1..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  2  per-channel level conversion request (bit0 = ch0, bit1 = ch1).
REQ-006 SHALL have port gnt  output  2  one-hot grant to the channel being converted; 0 otherwise.
REQ-007 SHALL have port ota_en  output  1  enable to the shared digital OTA/comparator datapath.
REQ-008 SHALL have port ota_sel  output  1  input-pair select for the OTA (0 = ch0 pair, 1 = ch1 pair).
REQ-009 SHALL have port cmp_in  input  1  comparator output, already synchronous to clk.
REQ-010 SHALL have port res_valid  output  1  conversion result available.
REQ-011 SHALL have port res_ack  input  1  result consumed.
REQ-012 SHALL have port res_ch  output  1  channel the result belongs to.
REQ-013 SHALL have port res_bit  output  1  majority-vote comparator decision.
REQ-014 SHALL have port res_ones  output  4  count of cmp_in = 1 samples in the conversion.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-017 IDLE: if req != 0, SHALL choose the channel and enter SETTLE next cycle; else stay in IDLE.
REQ-018 Arbitration: single request wins; both requested -> channel != last_ch (round-robin); last_ch updates on DONE exit.
REQ-019 SETTLE: gnt one-hot for chosen channel, ota_en = 1, ota_sel = channel; lasts exactly SETTLE_CYC cycles, then SAMPLE.
REQ-020 SAMPLE: gnt, ota_en, ota_sel held; lasts exactly NSAMP cycles; cmp_in sampled once per cycle, ones counter incremented on each 1.
REQ-021 DONE: gnt = 0, ota_en = 0; res_valid = 1; res_ch = channel; res_ones = ones count; res_bit = 1 iff res_ones > NSAMP/2 (integer).
REQ-022 res_ch, res_bit, res_ones SHALL be stable for the whole res_valid period and retain last values in IDLE.
REQ-023 DONE SHALL hold until res_ack = 1, then go to IDLE next cycle; res_ack outside DONE ignored.
REQ-024 Latency: req seen in IDLE at cycle t -> gnt at t+1, res_valid at t+1+SETTLE_CYC+NSAMP.
REQ-025 req deassertion during SETTLE/SAMPLE SHALL NOT abort; conversion completes and result is presented.
REQ-026 req changes on other channel during a conversion SHALL be ignored until next IDLE.
REQ-027 Back-to-back: at least one IDLE cycle between DONE and next SETTLE; ack with pending req -> next gnt two cycles after ack cycle.
REQ-028 Counters SHALL never wrap: settle and sample counters 4 bits, reloaded on each state entry.
REQ-029 gnt SHALL never have both bits set; ota_en SHALL equal (state is SETTLE or SAMPLE).

Reset
REQ-030 rst = 1 at a clock edge SHALL force IDLE regardless of state, including mid-conversion, discarding partial count.
REQ-031 After reset: gnt = 0, ota_en = 0, ota_sel = 0, res_valid = 0, res_ch = 0, res_bit = 0, res_ones = 0, busy = 0, last_ch = 1 (ch0 wins first tie).

Verification
REQ-032 Single request: req = 01 at t, cmp_in = 1,1,0,1,0 in SAMPLE -> gnt = 01 t+1..t+9, res_valid at t+10, res_ones = 3, res_bit = 1, res_ch = 0.
REQ-033 Tie arbitration: req = 11 held after reset, ack each result -> grants alternate ch0, ch1, ch0; each res_ch matches.
REQ-034 Minority vote: req = 10, cmp_in = 1,0,0,1,0 -> res_ones = 2, res_bit = 0, res_ch = 1, ota_sel = 1 during conversion.
REQ-035 Stall: no res_ack for 20 cycles in DONE -> res_valid and result fields stable, gnt = 0, ota_en = 0, new req not granted.
REQ-036 Mid-operation reset: rst = 1 during SAMPLE cycle 3 -> next cycle all outputs at REQ-031 values; fresh req converts normally.
REQ-037 Request drop: req = 01 for one cycle only -> full conversion completes with res_valid at t+10.
